// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache
// controller. Each line holds one word. Load hits return data in the same
// cycle. Load misses and all stores stall the CPU while one req/ack
// transaction runs on the backing memory. Byte lanes are big-endian:
// offset 0 is bits 31:24.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   cpu_re / cpu_we        load / store request (the store wins if both are high)
//   cpu_byte               1 = byte access, 0 = word access
//   cpu_addr, cpu_wdata    byte address, store data (byte store uses [7:0])
//   cpu_rdata, cpu_stall   load data (zero-extended for bytes), pipeline hold
//   mem_req/we/byte/addr/wdata  registered backing-memory request
//   mem_rdata, mem_ack     memory read data, one-cycle completion pulse
//   hit_count, miss_count  saturating load statistics (only with the macro below)
//
// Optional macro DCACHE_STATS_EN adds the hit_count/miss_count outputs.
//
// state | meaning
// IDLE  | serve load hits, detect load misses and stores
// FILL  | line refill read in flight
// WRITE | write-through store in flight
module dcache_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_WIDTH     = 8,
  parameter int TAG_WIDTH     = ADDRESS_WIDTH - SET_WIDTH - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_re,
  input  logic                     cpu_we,
  input  logic                     cpu_byte,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic                     mem_byte,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int SETS = 1 << SET_WIDTH;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e                     state_q;
  logic [SETS-1:0]            valid_q;
  logic [TAG_WIDTH-1:0]       tag_q  [SETS];
  logic [DATA_WIDTH-1:0]      data_q [SETS];
  // Set for the single IDLE cycle after a store completes: the CPU still
  // presents that store, which retires now and must not be re-issued.
  logic                       wr_done_q;
  logic                       mem_req_q, mem_we_q, mem_byte_q;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]      mem_wdata_q;

  logic [SET_WIDTH-1:0]       idx;
  logic [TAG_WIDTH-1:0]       tag;
  logic [1:0]                 off;
  logic [4:0]                 lane_lsb;
  logic [DATA_WIDTH-1:0]      line;
  logic [7:0]                 byte_sel;
  logic                       hit, ack, idle_go;
  logic                       load_hit, start_fill, start_write;

  assign idx      = cpu_addr[SET_WIDTH+1:2];
  assign tag      = cpu_addr[ADDRESS_WIDTH-1:SET_WIDTH+2];
  assign off      = cpu_addr[1:0];
  // Big-endian lane: offset 0 -> bits 31:24, offset 3 -> bits 7:0.
  assign lane_lsb = {~off, 3'b000};
  assign line     = data_q[idx];
  assign byte_sel = line[lane_lsb +: 8];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  // An ack outside an open request (including a late one after reset) is dropped.
  assign ack      = mem_ack && mem_req_q;

  assign idle_go     = (state_q == IDLE) && !wr_done_q;
  assign start_write = idle_go && cpu_we;
  assign start_fill  = idle_go && cpu_re && !cpu_we && !hit;
  assign load_hit    = idle_go && cpu_re && !cpu_we && hit;

  assign cpu_stall = (state_q != IDLE) || start_fill || start_write;
  assign cpu_rdata = !load_hit ? '0 :
                     cpu_byte  ? DATA_WIDTH'(byte_sel) : line;

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_byte  = mem_byte_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      wr_done_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wr_done_q <= 1'b0;
          if (start_write) begin
            state_q     <= WRITE;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_byte_q  <= cpu_byte;
            mem_addr_q  <= cpu_byte ? cpu_addr : {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
            mem_wdata_q <= cpu_wdata;
          end else if (start_fill) begin
            state_q     <= FILL;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_byte_q  <= 1'b0;
            mem_addr_q  <= {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
          end
        end
        FILL: begin
          if (ack) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            valid_q[idx] <= 1'b1;
          end
        end
        WRITE: begin
          if (ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            wr_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk) begin
    if (state_q == FILL && ack) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= mem_rdata;
    end else if (state_q == WRITE && ack && hit) begin
      if (cpu_byte) data_q[idx][lane_lsb +: 8] <= cpu_wdata[7:0];
      else          data_q[idx]                <= cpu_wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit && hit_count != 32'hFFFF_FFFF)     hit_count  <= hit_count + 32'd1;
      if (start_fill && miss_count != 32'hFFFF_FFFF)  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_re, cpu_we, cpu_byte;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_re    (cpu_re),
    .cpu_we    (cpu_we),
    .cpu_byte  (cpu_byte),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_byte  (mem_byte),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: backing memory as words, cache as per-set valid/tag.
  // Write-through keeps the cache coherent, so expected load data always
  // comes straight from the memory model.
  logic [31:0] memw [int unsigned];
  bit          m_valid [256];
  int unsigned m_tag   [256];
  int unsigned m_hits = 0, m_misses = 0;
  logic [31:0] last_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (!memw.exists(a[31:2])) memw[a[31:2]] = $urandom;
    return memw[a[31:2]];
  endfunction

  function automatic int unsigned lane_shift(input logic [31:0] a);
    return 8 * (3 - int'(a[1:0]));
  endfunction

  task automatic access(input bit we, input bit byt, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat);
    int unsigned idx = int'(addr[9:2]);
    int unsigned tg  = int'(addr[31:10]);
    bit          hit = m_valid[idx] && (m_tag[idx] == tg);
    logic [31:0] w, expd, mask, expa;
    int          nstall;
    w    = mem_word(addr);
    expd = byt ? ((w >> lane_shift(addr)) & 32'hFF) : w;
    @(posedge clk); #1;
    cpu_we = we; cpu_re = we ? 1'($urandom_range(0, 1)) : 1'b1;
    cpu_byte = byt; cpu_addr = addr; cpu_wdata = wd;
    @(negedge clk);
    if (!we && hit) begin
      chk("hit_stall", {31'b0, cpu_stall}, 32'd0);
      chk("hit_rdata", cpu_rdata, expd);
      chk("hit_noreq", {31'b0, mem_req}, 32'd0);
      last_rdata = cpu_rdata;
      m_hits++;
      @(posedge clk); #1;
      cpu_re = 1'b0; cpu_we = 1'b0;
      return;
    end
    chk("detect_stall", {31'b0, cpu_stall}, 32'd1);
    nstall = int'(cpu_stall);
    expa = (we && byt) ? addr : {addr[31:2], 2'b00};
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      nstall += int'(cpu_stall);
      if (c == 1) begin
        chk("req", {31'b0, mem_req}, 32'd1);
        chk("req_we", {31'b0, mem_we}, {31'b0, we});
        chk("req_byte", {31'b0, mem_byte}, {31'b0, we & byt});
        chk("req_addr", mem_addr, expa);
        if (we) chk("req_wdata", mem_wdata, wd);
      end
      if (c == lat) begin
        mem_ack = 1'b1;
        mem_rdata = we ? $urandom : w;
      end
    end
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    chk("stall_cycles", nstall, lat + 1);
    chk("req_dropped", {31'b0, mem_req}, 32'd0);
    chk("done_stall", {31'b0, cpu_stall}, 32'd0);
    if (we) begin
      if (byt) begin
        mask = 32'hFF << lane_shift(addr);
        memw[addr[31:2]] = (w & ~mask) | ({24'b0, wd[7:0]} << lane_shift(addr));
      end else begin
        memw[addr[31:2]] = wd;
      end
    end else begin
      chk("fill_rdata", cpu_rdata, expd);
      last_rdata = cpu_rdata;
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_misses++;
      m_hits++;
    end
    @(posedge clk); #1;
    cpu_re = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic expect_miss_next(input string tag, input logic [31:0] addr);
    chk(tag, {31'b0, m_valid[addr[9:2]] && m_tag[addr[9:2]] == int'(addr[31:10])}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    rst_n = 1'b0; cpu_re = 0; cpu_we = 0; cpu_byte = 0;
    cpu_addr = 0; cpu_wdata = 0; mem_rdata = 0; mem_ack = 0;
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    #12;
    chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    memw[32'h00010000 >> 2] = 32'h11223344;
    access(0, 0, 32'h00010000, 0, 2);
    chk("cold_rdata", last_rdata, 32'h11223344);
    access(0, 0, 32'h00010000, 0, 1);
    chk("repeat_rdata", last_rdata, 32'h11223344);
    access(0, 1, 32'h00010001, 0, 1);
    chk("byte_rdata", last_rdata, 32'h00000022);
    access(1, 1, 32'h00010002, 32'h5A5A5AAB, 3);
    access(0, 0, 32'h00010000, 0, 1);
    chk("merge_rdata", last_rdata, 32'h1122AB44);
    access(1, 0, 32'h00020000, 32'hDEADBEEF, 2);
    expect_miss_next("store_no_alloc", 32'h00020000);
    access(0, 0, 32'h00020000, 0, 2);
    chk("store_miss_rdata", last_rdata, 32'hDEADBEEF);
    access(0, 0, 32'h00010400, 0, 1);
    expect_miss_next("alias_evict", 32'h00010000);
    access(0, 0, 32'h00010000, 0, 2);

    // Reset in the middle of a refill.
    expect_miss_next("pre_reset_miss", 32'h00030000);
    @(posedge clk); #1;
    cpu_re = 1'b1; cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h00030000;
    @(negedge clk);
    chk("rfill_stall", {31'b0, cpu_stall}, 32'd1);
    @(negedge clk);
    chk("rfill_req", {31'b0, mem_req}, 32'd1);
    #2 rst_n = 1'b0; cpu_re = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, cpu_stall}, 32'd0);
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    m_hits = 0; m_misses = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hBADBAD00;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_req", {31'b0, mem_req}, 32'd0);
    chk("late_ack_stall", {31'b0, cpu_stall}, 32'd0);
    access(0, 0, 32'h00010000, 0, 2);

    // Random traffic over a few tags and sets so hits, aliases and stores mix.
    for (int n = 0; n < 300; n++) begin
      a = {12'h000, 4'($urandom_range(1, 3)), 6'h00, 8'($urandom_range(0, 3)), 2'($urandom)};
      if ($urandom_range(0, 2) == 0)
        access(1, 1'($urandom), a, $urandom, int'($urandom_range(1, 4)));
      else
        access(0, 1'($urandom), a, 0, int'($urandom_range(1, 4)));
    end

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
